// File: rtl/sram_ctrl_if.sv
// Request/response bus between an initiator and the SRAM controller.
// The master modport drives requests and accepts responses; the slave modport is the controller side.
interface sram_ctrl_if #(
   parameter int ADDR_W = 2,
   parameter int DATA_W = 2
);
   logic              req_valid;
   logic              req_ready;
   logic              req_we;
   logic [ADDR_W-1:0] req_addr;
   logic [DATA_W-1:0] req_wdata;
   logic              rsp_valid;
   logic              rsp_ready;
   logic [DATA_W-1:0] rsp_rdata;

   modport master (
      output req_valid, req_we, req_addr, req_wdata, rsp_ready,
      input  req_ready, rsp_valid, rsp_rdata
   );

   modport slave (
      input  req_valid, req_we, req_addr, req_wdata, rsp_ready,
      output req_ready, rsp_valid, rsp_rdata
   );
endinterface

// File: rtl/sram_ctrl.sv
// Single-port SRAM initiator: valid/ready requests in, registered SRAM cycles out, read data on a response channel.
// Optional SRAM_CTRL_INIT_CLEAR_EN: after reset, zero every SRAM word before accepting requests.
module sram_ctrl #(
   parameter int ADDR_W = 2,
   parameter int DATA_W = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   sram_ctrl_if.slave        bus,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              busy
);

`ifdef SRAM_CTRL_INIT_CLEAR_EN
   typedef enum logic [1:0] {IDLE, ACCESS, RESP, INIT} state_t;
   localparam state_t RESET_STATE = INIT;
   localparam logic [ADDR_W:0] CNT_ONE = {{ADDR_W{1'b0}}, 1'b1};

   // Extra MSB flags that every address has already been presented.
   logic [ADDR_W:0] init_cnt;
`else
   typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
   localparam state_t RESET_STATE = IDLE;
`endif

   state_t state;
   state_t state_next;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= RESET_STATE;
      end else begin
         state <= state_next;
      end
   end

   // ACCESS is always one cycle; the latched write enable picks the exit.
   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (bus.req_valid) state_next = ACCESS;
         ACCESS:  state_next = mem_we ? IDLE : RESP;
         RESP:    if (bus.rsp_ready) state_next = IDLE;
`ifdef SRAM_CTRL_INIT_CLEAR_EN
         INIT:    if (init_cnt[ADDR_W]) state_next = IDLE;
`endif
         default: state_next = IDLE;
      endcase
   end

   assign bus.req_ready = (state == IDLE);
   assign busy          = (state != IDLE);

   // mem_we defaults low so it is high only for the single cycle after a write is latched.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         mem_we        <= 1'b0;
         mem_addr      <= '0;
         mem_wdata     <= '0;
         bus.rsp_valid <= 1'b0;
         bus.rsp_rdata <= '0;
`ifdef SRAM_CTRL_INIT_CLEAR_EN
         init_cnt      <= '0;
`endif
      end else begin
         mem_we <= 1'b0;
         case (state)
            IDLE: begin
               if (bus.req_valid) begin
                  mem_we    <= bus.req_we;
                  mem_addr  <= bus.req_addr;
                  mem_wdata <= bus.req_wdata;
               end
            end
            ACCESS: begin
               if (!mem_we) begin
                  bus.rsp_rdata <= mem_rdata;
                  bus.rsp_valid <= 1'b1;
               end
            end
            RESP: begin
               if (bus.rsp_ready) bus.rsp_valid <= 1'b0;
            end
`ifdef SRAM_CTRL_INIT_CLEAR_EN
            INIT: begin
               if (!init_cnt[ADDR_W]) begin
                  mem_we    <= 1'b1;
                  mem_addr  <= init_cnt[ADDR_W-1:0];
                  mem_wdata <= '0;
                  init_cnt  <= init_cnt + CNT_ONE;
               end
            end
`endif
            default: ;
         endcase
      end
   end

endmodule
